// File: rtl/liang_if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : liang_if_stage_if
// Brief    : Fetch-stage bundle: redirect, imem request/response, decode, perf.
// Revision : 1.0
// ============================================================================
interface liang_if_stage_if;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        if2id_valid_o;
  logic        if2id_ready_i;
  logic [63:0] if2id_o;
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_redirect_cnt_o;
  logic [31:0] perf_stall_cnt_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i, imem_req_ready_i,
           imem_resp_valid_i, imem_resp_data_i, if2id_ready_i,
    output imem_req_valid_o, imem_req_addr_o, if2id_valid_o, if2id_o,
           perf_fetch_cnt_o, perf_redirect_cnt_o, perf_stall_cnt_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, imem_req_ready_i,
           imem_resp_valid_i, imem_resp_data_i, if2id_ready_i,
    input  imem_req_valid_o, imem_req_addr_o, if2id_valid_o, if2id_o,
           perf_fetch_cnt_o, perf_redirect_cnt_o, perf_stall_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/liang_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : liang_if_stage
// Brief    : Instruction fetch with credit-limited requests, {pc,inst} queue and
//            redirect drop tracking. Optional counters: LIANG_IFU_PERF_EN.
// Revision : 1.0
// ============================================================================
module liang_if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  liang_if_stage_if.master bus
);
  localparam int unsigned       c_IDX_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned       c_PTR_W = c_IDX_W + 1;
  localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W + 1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic               flag;
    logic [c_IDX_W-1:0] idx;
  } ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t n;
    {n.flag, n.idx} = {p.flag, p.idx} + c_PTR_W'(1);
    return n;
  endfunction

  logic [31:0]        r_pc;
  ptr_t               r_wr_ptr;
  ptr_t               r_rd_ptr;
  logic [c_PTR_W-1:0] r_outst;
  logic [c_PTR_W-1:0] r_drop;
  logic [c_IDX_W-1:0] r_opc_wr;
  logic [c_IDX_W-1:0] r_opc_rd;
  logic [31:0]        r_opc_mem  [QUEUE_DEPTH];
  logic [31:0]        r_pc_mem   [QUEUE_DEPTH];
  logic [31:0]        r_inst_mem [QUEUE_DEPTH];

  logic               w_redirect;
  logic               w_empty;
  logic               w_full;
  logic [c_PTR_W-1:0] w_occ;
  logic [c_PTR_W:0]   w_credit;
  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_out_valid;
  logic               w_deq;
  logic               w_resp;
  logic               w_dropping;
  logic               w_enq;
  logic [c_PTR_W-1:0] w_outst_next;
  logic               w_unused;

  assign w_redirect = bus.redirect_valid_i;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr.idx == r_rd_ptr.idx) && (r_wr_ptr.flag != r_rd_ptr.flag);
  assign w_occ      = r_wr_ptr - r_rd_ptr;

  // Queued entries plus in-flight requests never exceed the queue, so every
  // response is guaranteed a slot without backpressure.
  assign w_credit    = {1'b0, w_occ} + {1'b0, r_outst};
  assign w_req_valid = !rst && !w_redirect && (w_credit < c_DEPTH);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready_i;

  assign w_out_valid = !rst && !w_empty && !w_redirect;
  assign w_deq       = w_out_valid && bus.if2id_ready_i;

  assign w_resp       = bus.imem_resp_valid_i;
  assign w_dropping   = (r_drop != '0) || w_redirect;
  assign w_enq        = w_resp && !w_dropping && (!w_full || w_deq);
  assign w_outst_next = r_outst + c_PTR_W'(w_req_fire) - c_PTR_W'(w_resp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= {RESET_PC[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_outst  <= '0;
      r_drop   <= '0;
      r_opc_wr <= '0;
      r_opc_rd <= '0;
    end else begin
      r_outst <= w_outst_next;
      if (w_req_fire) r_opc_wr <= r_opc_wr + c_IDX_W'(1);
      if (w_resp)     r_opc_rd <= r_opc_rd + c_IDX_W'(1);
      if (w_enq)      r_wr_ptr <= ptr_inc(r_wr_ptr);

      if (w_redirect) begin
        r_pc     <= {bus.redirect_pc_i[31:2], 2'b00};
        r_rd_ptr <= r_wr_ptr;
        // Everything still in flight after this edge belongs to the old path.
        r_drop   <= w_outst_next;
      end else begin
        if (w_req_fire) r_pc <= r_pc + 32'd4;
        if (w_deq)      r_rd_ptr <= ptr_inc(r_rd_ptr);
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - c_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) r_opc_mem[r_opc_wr] <= r_pc;
    if (w_enq) begin
      r_pc_mem[r_wr_ptr.idx]   <= r_opc_mem[r_opc_rd];
      r_inst_mem[r_wr_ptr.idx] <= bus.imem_resp_data_i;
    end
  end

  assign bus.imem_req_valid_o = w_req_valid;
  assign bus.imem_req_addr_o  = r_pc;
  assign bus.if2id_valid_o    = w_out_valid;
  assign bus.if2id_o          = {r_pc_mem[r_rd_ptr.idx], r_inst_mem[r_rd_ptr.idx]};

`ifdef LIANG_IFU_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_redirect;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch    <= '0;
      r_perf_redirect <= '0;
      r_perf_stall    <= '0;
    end else begin
      if (w_req_fire)                          r_perf_fetch    <= r_perf_fetch + 32'd1;
      if (w_redirect)                          r_perf_redirect <= r_perf_redirect + 32'd1;
      if (w_out_valid && !bus.if2id_ready_i)   r_perf_stall    <= r_perf_stall + 32'd1;
    end
  end

  assign bus.perf_fetch_cnt_o    = r_perf_fetch;
  assign bus.perf_redirect_cnt_o = r_perf_redirect;
  assign bus.perf_stall_cnt_o    = r_perf_stall;
`else
  assign bus.perf_fetch_cnt_o    = '0;
  assign bus.perf_redirect_cnt_o = '0;
  assign bus.perf_stall_cnt_o    = '0;
`endif

  assign w_unused = &{1'b0, bus.redirect_pc_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_liang_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_liang_if_stage
// Brief    : Directed self-checking bench; memory returns ~addr as instruction.
// Revision : 1.0
// ============================================================================
module tb_liang_if_stage;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef LIANG_IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  liang_if_stage_if bus();

  liang_if_stage #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mem_lat = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [31:0] out_pc[$];
  logic [31:0] out_inst[$];

  // Memory responder and handshake monitor: responses driven at the falling
  // edge, handshakes sampled just before the rising edge.
  initial begin
    bus.imem_resp_valid_i = 1'b0;
    bus.imem_resp_data_i  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        bus.imem_resp_valid_i = 1'b1;
        bus.imem_resp_data_i  = ~mq_addr[0];
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.imem_resp_valid_i = 1'b0;
        bus.imem_resp_data_i  = '0;
      end
      #4;
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
        bus.imem_resp_valid_i = 1'b0;
      end else begin
        if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
          mq_addr.push_back(bus.imem_req_addr_o);
          mq_due.push_back(cyc + mem_lat);
          req_log.push_back(bus.imem_req_addr_o);
        end
        if (bus.if2id_valid_o && bus.if2id_ready_i) begin
          out_pc.push_back(bus.if2id_o[63:32]);
          out_inst.push_back(bus.if2id_o[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // Returns at the falling edge that starts cycle 0 after release.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid_i = 1'b0;
    req_log.delete();
    out_pc.delete();
    out_inst.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %0b want 0", bus.imem_req_valid_o); end
    n_cmp++; if (bus.if2id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_if2id_valid: got %0b want 0", bus.if2id_valid_o); end
    n_cmp++; if (bus.perf_fetch_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_perf_fetch: got %0d want 0", bus.perf_fetch_cnt_o); end
    n_cmp++; if (bus.perf_stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_perf_stall: got %0d want 0", bus.perf_stall_cnt_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL release_req_valid: got %0b want 1", bus.imem_req_valid_o); end
    n_cmp++; if (bus.imem_req_addr_o !== RESET_PC) begin n_fail++; $display("FAIL release_req_addr: got %h want %h", bus.imem_req_addr_o, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    mem_lat = 1;
    bus.if2id_ready_i = 1'b1;
    apply_reset();
    repeat (14) @(negedge clk);
    #1;
    n_cmp++; if (out_pc.size() < 6) begin n_fail++; $display("FAIL stream_out_count: got %0d want >=6", out_pc.size()); end
    n_cmp++; if (req_log.size() < 6) begin n_fail++; $display("FAIL stream_req_count: got %0d want >=6", req_log.size()); end
    for (int i = 0; i < 6; i++) begin
      exp_pc = RESET_PC + 32'(4 * i);
      if (i < req_log.size()) begin
        n_cmp++; if (req_log[i] !== exp_pc) begin n_fail++; $display("FAIL stream_req[%0d]: got %h want %h", i, req_log[i], exp_pc); end
      end
      if (i < out_pc.size()) begin
        n_cmp++; if (out_pc[i] !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc[i], exp_pc); end
        n_cmp++; if (out_inst[i] !== ~exp_pc) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h want %h", i, out_inst[i], ~exp_pc); end
      end
    end
  endtask

  task automatic test_stall();
    int k;
    logic [31:0] exp_cnt;
    mem_lat = 1;
    bus.if2id_ready_i = 1'b0;
    apply_reset();
    #1;
    k = 0;
    while (!bus.if2id_valid_o && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    n_cmp++; if (k >= 20) begin n_fail++; $display("FAIL stall_wait_valid: got timeout want valid"); end
    n_cmp++; if (bus.perf_stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL stall_cnt_start: got %0d want 0", bus.perf_stall_cnt_o); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (bus.if2id_valid_o !== 1'b1 || bus.if2id_o !== {RESET_PC, ~RESET_PC}) begin
        n_fail++; $display("FAIL stall_frozen[%0d]: got v=%0b %h want v=1 %h", i, bus.if2id_valid_o, bus.if2id_o, {RESET_PC, ~RESET_PC});
      end
      @(negedge clk); #1;
    end
    exp_cnt = PERF ? 32'd10 : 32'd0;
    n_cmp++; if (bus.perf_stall_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt_end: got %0d want %0d", bus.perf_stall_cnt_o, exp_cnt); end
    exp_cnt = PERF ? 32'd2 : 32'd0;
    n_cmp++; if (bus.perf_fetch_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL stall_fetch_cnt: got %0d want %0d", bus.perf_fetch_cnt_o, exp_cnt); end
    n_cmp++; if (req_log.size() !== 2) begin n_fail++; $display("FAIL stall_req_count: got %0d want 2", req_log.size()); end
    bus.if2id_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (out_pc.size() < 3) begin n_fail++; $display("FAIL stall_drain_count: got %0d want >=3", out_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < out_pc.size()) begin
        n_cmp++; if (out_pc[i] !== RESET_PC + 32'(4 * i)) begin n_fail++; $display("FAIL stall_drain_pc[%0d]: got %h want %h", i, out_pc[i], RESET_PC + 32'(4 * i)); end
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_req [4];
    logic [31:0] exp_cnt;
    exp_req = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0100, 32'h8000_0104};
    mem_lat = 3;
    bus.if2id_ready_i = 1'b1;
    apply_reset();
    repeat (2) @(negedge clk);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0103;
    #1;
    n_cmp++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_req_valid: got %0b want 0", bus.imem_req_valid_o); end
    @(negedge clk);
    bus.redirect_valid_i = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    n_cmp++; if (req_log.size() < 4) begin n_fail++; $display("FAIL redir_req_count: got %0d want >=4", req_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < req_log.size()) begin
        n_cmp++; if (req_log[i] !== exp_req[i]) begin n_fail++; $display("FAIL redir_req[%0d]: got %h want %h", i, req_log[i], exp_req[i]); end
      end
    end
    n_cmp++;
    if (out_pc.size() < 2 || out_pc[0] !== 32'h8000_0100 || out_inst[0] !== ~32'h8000_0100 || out_pc[1] !== 32'h8000_0104) begin
      n_fail++; $display("FAIL redir_first_out: got n=%0d pc0=%h want pc0=80000100 pc1=80000104", out_pc.size(), (out_pc.size() > 0) ? out_pc[0] : 32'h0);
    end
    exp_cnt = PERF ? 32'd1 : 32'd0;
    n_cmp++; if (bus.perf_redirect_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL redir_cnt: got %0d want %0d", bus.perf_redirect_cnt_o, exp_cnt); end
  endtask

  task automatic test_redirect_coincident();
    mem_lat = 1;
    bus.if2id_ready_i = 1'b1;
    apply_reset();
    repeat (2) @(negedge clk);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h9000_0000;
    #1;
    n_cmp++; if (bus.if2id_valid_o !== 1'b0) begin n_fail++; $display("FAIL coinc_valid_redir: got %0b want 0", bus.if2id_valid_o); end
    @(negedge clk);
    bus.redirect_valid_i = 1'b0;
    #1;
    n_cmp++; if (bus.if2id_valid_o !== 1'b0) begin n_fail++; $display("FAIL coinc_empty_after: got %0b want 0", bus.if2id_valid_o); end
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if (req_log.size() < 3 || req_log[2] !== 32'h9000_0000) begin n_fail++; $display("FAIL coinc_req2: got n=%0d want 90000000 at index 2", req_log.size()); end
    n_cmp++; if (out_pc.size() < 1 || out_pc[0] !== 32'h9000_0000) begin n_fail++; $display("FAIL coinc_first_out: got n=%0d pc0=%h want 90000000", out_pc.size(), (out_pc.size() > 0) ? out_pc[0] : 32'h0); end
  endtask

  task automatic test_back_to_back();
    mem_lat = 3;
    bus.if2id_ready_i = 1'b1;
    apply_reset();
    @(negedge clk);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'hA000_0000;
    @(negedge clk);
    bus.redirect_pc_i    = 32'hB000_0000;
    @(negedge clk);
    bus.redirect_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (req_log.size() < 3 || req_log[1] !== 32'hB000_0000 || req_log[2] !== 32'hB000_0004) begin n_fail++; $display("FAIL b2b_req: got n=%0d want 80000000,b0000000,b0000004", req_log.size()); end
    n_cmp++; if (out_pc.size() < 1 || out_pc[0] !== 32'hB000_0000) begin n_fail++; $display("FAIL b2b_first_out: got n=%0d pc0=%h want b0000000", out_pc.size(), (out_pc.size() > 0) ? out_pc[0] : 32'h0); end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    bus.if2id_ready_i = 1'b1;
    apply_reset();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.redirect_valid_i = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    n_cmp++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_req: got n=%0d want fffffffc,00000000", req_log.size()); end
    n_cmp++; if (out_pc.size() < 2 || out_pc[0] !== 32'hFFFF_FFFC || out_pc[1] !== 32'h0000_0000 || out_inst[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_out: got n=%0d want pcs fffffffc,00000000", out_pc.size()); end
  endtask

  task automatic test_reset_mid();
    mem_lat = 2;
    bus.if2id_ready_i = 1'b0;
    apply_reset();
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if (bus.if2id_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %0b want 1", bus.if2id_valid_o); end
    #1;
    rst = 1'b1;
    req_log.delete();
    out_pc.delete();
    out_inst.delete();
    #1;
    n_cmp++; if (bus.if2id_valid_o !== 1'b0 || bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_valids: got if2id=%0b req=%0b want 0 0", bus.if2id_valid_o, bus.imem_req_valid_o); end
    n_cmp++; if ({bus.perf_fetch_cnt_o, bus.perf_redirect_cnt_o, bus.perf_stall_cnt_o} !== 96'd0) begin n_fail++; $display("FAIL mid_counters: got %0d %0d %0d want 0 0 0", bus.perf_fetch_cnt_o, bus.perf_redirect_cnt_o, bus.perf_stall_cnt_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== RESET_PC) begin n_fail++; $display("FAIL mid_first_req: got v=%0b %h want v=1 %h", bus.imem_req_valid_o, bus.imem_req_addr_o, RESET_PC); end
    bus.if2id_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    n_cmp++; if (out_pc.size() < 1 || out_pc[0] !== RESET_PC) begin n_fail++; $display("FAIL mid_first_out: got n=%0d pc0=%h want %h", out_pc.size(), (out_pc.size() > 0) ? out_pc[0] : 32'h0, RESET_PC); end
  endtask

  initial begin
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.imem_req_ready_i = 1'b1;
    bus.if2id_ready_i    = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_coincident();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
